// File: rtl/hex_disp_pkg.sv
// ---------------------------------------------------------------------------
// | Module      : hex_disp_pkg                                              |
// | Description : Shared constants for the multi-digit hex display bank:    |
// |               blank pattern, active-low 7-seg lookup table, and the     |
// |               decoder state encoding.                                   |
// | Revision    : 1.0 - initial release                                     |
// ---------------------------------------------------------------------------
`default_nettype none

package hex_disp_pkg;

  // All segments off (active-low outputs).
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Hex digit -> segments g..a, 0 = lit.
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    DECODE = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/hex_display_bank_if.sv
// ---------------------------------------------------------------------------
// | Module      : hex_display_bank_if                                       |
// | Description : valid/ready input bus carrying a packed NUM_DIGITS x 4-bit|
// |               value into the hex display bank.                          |
// | Revision    : 1.0 - initial release                                     |
// ---------------------------------------------------------------------------
`default_nettype none

interface hex_display_bank_if #(
  parameter int NUM_DIGITS = 6
);
  logic [4*NUM_DIGITS-1:0] in_data;
  logic                    in_valid;
  logic                    in_ready;

  modport master (output in_data, output in_valid, input  in_ready);
  modport slave  (input  in_data, input  in_valid, output in_ready);
endinterface

`default_nettype wire

// File: rtl/hex_seg_lut.sv
// ---------------------------------------------------------------------------
// | Module      : hex_seg_lut                                               |
// | Description : Combinational 4-bit hex digit to active-low 7-segment     |
// |               pattern (bit6..0 = g..a).                                 |
// | Revision    : 1.0 - initial release                                     |
// ---------------------------------------------------------------------------
`default_nettype none

module hex_seg_lut
  import hex_disp_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  assign seg = SEG_LUT[digit];

endmodule

`default_nettype wire

// File: rtl/hex_display_bank.sv
// ---------------------------------------------------------------------------
// | Module      : hex_display_bank                                          |
// | Description : Accepts a NUM_DIGITS hex value over valid/ready, decodes  |
// |               one digit per clock into a shadow buffer, then commits    |
// |               all digits at once to active-low 7-seg outputs, with an   |
// |               optional blink mask.                                      |
// | Options     : HEX_DISP_LZB_EN - leading-zero blanking at commit         |
// | Revision    : 1.0 - initial release                                     |
// ---------------------------------------------------------------------------
`default_nettype none

module hex_display_bank
  import hex_disp_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int BLINK_DIV  = 2**24
) (
  input  logic                    clk,
  input  logic                    rst_n,
  hex_display_bank_if.slave       bus,
  input  logic                    blink_en,
  output logic [7*NUM_DIGITS-1:0] hex_out,
  output logic                    done
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = (BLINK_DIV  > 1) ? $clog2(BLINK_DIV)  : 1;

  state_t                  state_q, state_d;
  logic                    accept, commit;
  logic                    ready_q;
  logic                    done_q;
  logic [4*NUM_DIGITS-1:0] data_q;
  logic [IW-1:0]           idx_q;
  logic [3:0]              cur_digit;
  logic [6:0]              lut_seg;
  logic [6:0]              shadow_q [NUM_DIGITS];
  logic [7*NUM_DIGITS-1:0] seg_q, seg_d;
  logic [7*NUM_DIGITS-1:0] hex_q;
  logic [NUM_DIGITS-1:0]   keep;
  logic [CW-1:0]           blink_cnt_q;
  logic                    phase_off_q;

  assign cur_digit = data_q[4*int'(idx_q) +: 4];

  hex_seg_lut u_lut (
    .digit (cur_digit),
    .seg   (lut_seg)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: accept in IDLE, commit on the last digit of DECODE.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (ready_q && bus.in_valid) begin
          accept  = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (idx_q == IW'(NUM_DIGITS - 1)) begin
          commit  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Ready is registered so it stays low through reset and rises one edge later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      ready_q <= (state_d == IDLE);
      done_q  <= commit;
    end
  end

  // Input latch, digit index and shadow buffer fill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      idx_q  <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) shadow_q[i] <= SEG_BLANK;
    end else if (accept) begin
      data_q <= bus.in_data;
      idx_q  <= '0;
    end else if (state_q == DECODE) begin
      shadow_q[idx_q] <= lut_seg;
      idx_q           <= commit ? '0 : idx_q + 1'b1;
    end
  end

  // Which digits remain visible at commit (leading zeros optionally blanked).
`ifdef HEX_DISP_LZB_EN
  logic seen_nz;
  always_comb begin
    keep    = '1;
    seen_nz = 1'b0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      seen_nz = seen_nz | (data_q[4*i +: 4] != 4'h0);
      keep[i] = seen_nz;
    end
  end
`else
  always_comb begin
    keep = '1;
  end
`endif

  // Next segment image: the last digit comes straight from the LUT so the
  // whole value lands in one edge.
  always_comb begin
    seg_d = seg_q;
    if (commit) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (!keep[i])                seg_d[7*i +: 7] = SEG_BLANK;
        else if (IW'(i) == idx_q)    seg_d[7*i +: 7] = lut_seg;
        else                         seg_d[7*i +: 7] = shadow_q[i];
      end
    end
  end

  // Committed segment register and masked, registered display output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= {NUM_DIGITS{SEG_BLANK}};
      hex_q <= {NUM_DIGITS{SEG_BLANK}};
    end else begin
      seg_q <= seg_d;
      hex_q <= (blink_en && phase_off_q) ? {NUM_DIGITS{SEG_BLANK}} : seg_d;
    end
  end

  // Free-running blink timer; phase flips each time the counter wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_q <= '0;
      phase_off_q <= 1'b0;
    end else if (blink_cnt_q == CW'(BLINK_DIV - 1)) begin
      blink_cnt_q <= '0;
      phase_off_q <= ~phase_off_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + 1'b1;
    end
  end

  assign bus.in_ready = ready_q;
  assign hex_out      = hex_q;
  assign done         = done_q;

endmodule

`default_nettype wire
